// File: rtl/mc_control_unit.sv
// Multicycle control FSM for a small MIPS subset (R-type ALU ops, lw/sw, beq, addi, j).
// Moore outputs derived from the current state and the memory wait counter.
module mc_control_unit #(
    parameter int MEM_LAT = 0,
    parameter bit EN_IMM  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OP,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       Reg_WE,
    output logic       DM_WE,
    output logic       ALU_src,
    output logic       MEM_to_REG,
    output logic       REG_Dst,
    output logic       IR_WE,
    output logic       PC_WE,
    output logic       ALU_srcA,
    output logic [1:0] ALU_OP,
    output logic [1:0] PC_src,
    output logic       ALU_srcB_pc4,
    output logic       illegal,
    output logic [3:0] state,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     cur;
    state_t     nxt;
    logic [3:0] wait_cnt;
    logic       wait_done;
    logic       funct_ok;

    assign wait_done = (wait_cnt == LAT);
    assign state     = cur;
    assign funct_ok  = (funct == 6'b100000) || (funct == 6'b100010) ||
                       (funct == 6'b100100) || (funct == 6'b100101) ||
                       (funct == 6'b101010);

    // The wait counter restarts on every state change, so it only ever counts within a wait state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= IDLE;
            wait_cnt <= 4'd0;
            illegal  <= 1'b0;
        end else begin
            cur      <= nxt;
            wait_cnt <= (nxt == cur) ? wait_cnt + 4'd1 : 4'd0;
            if (cur == DECODE && nxt == FETCH)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:   nxt = FETCH;
            FETCH:  if (wait_done) nxt = DECODE;
            DECODE: begin
                // Anything without a legal target falls back to FETCH and marks illegal.
                nxt = FETCH;
                case (OP)
                    6'b000000:              if (funct_ok) nxt = EXEC;
                    6'b100011, 6'b101011:   nxt = MEMADR;
                    6'b000100:              nxt = BRANCH;
                    6'b001000:              if (EN_IMM) nxt = ADDIEX;
                    6'b000010:              if (EN_IMM) nxt = JUMP;
                    default:                nxt = FETCH;
                endcase
            end
            MEMADR: nxt = (OP == 6'b100011) ? MEMRD : MEMWR;
            MEMRD:  if (wait_done) nxt = MEMWB;
            MEMWR:  if (wait_done) nxt = FETCH;
            EXEC:   nxt = ALUWB;
            ADDIEX: nxt = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: nxt = FETCH;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        Reg_WE       = 1'b0;
        DM_WE        = 1'b0;
        ALU_src      = 1'b0;
        MEM_to_REG   = 1'b0;
        REG_Dst      = 1'b0;
        IR_WE        = 1'b0;
        PC_WE        = 1'b0;
        ALU_srcA     = 1'b0;
        ALU_OP       = 2'b00;
        PC_src       = 2'b00;
        ALU_srcB_pc4 = 1'b0;
        instr_done   = 1'b0;
        case (cur)
            FETCH: begin
                IR_WE        = wait_done;
                PC_WE        = wait_done;
                ALU_srcB_pc4 = wait_done;
            end
            MEMADR: begin
                ALU_srcA = 1'b1;
                ALU_src  = 1'b1;
            end
            MEMWB: begin
                Reg_WE     = 1'b1;
                MEM_to_REG = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                DM_WE      = 1'b1;
                instr_done = wait_done;
            end
            EXEC: begin
                ALU_srcA = 1'b1;
                ALU_OP   = 2'b10;
            end
            ALUWB: begin
                Reg_WE     = 1'b1;
                REG_Dst    = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALU_srcA   = 1'b1;
                ALU_OP     = 2'b01;
                PC_src     = 2'b01;
                PC_WE      = zero;
                instr_done = 1'b1;
            end
            ADDIEX: begin
                ALU_srcA = 1'b1;
                ALU_src  = 1'b1;
            end
            ADDIWB: begin
                Reg_WE     = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                PC_WE      = 1'b1;
                PC_src     = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench: three control units with different latency/immediate settings, each fed
// directed and random instructions; expected per-cycle traces come from an instruction-level model.
module tb_mc_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                           S_JUMP = 4'd12;

    // Output vector layout: Reg_WE DM_WE ALU_src MEM_to_REG REG_Dst IR_WE PC_WE ALU_srcA
    // ALU_OP[1:0] PC_src[1:0] ALU_srcB_pc4 illegal instr_done
    localparam logic [14:0] M_REGWE = 15'h4000, M_DMWE = 15'h2000, M_SRC = 15'h1000,
                            M_M2R = 15'h0800, M_DST = 15'h0400, M_IRWE = 15'h0200,
                            M_PCWE = 15'h0100, M_SRCA = 15'h0080, M_OPFN = 15'h0040,
                            M_OPSUB = 15'h0020, M_PCJMP = 15'h0010, M_PCALUOUT = 15'h0008,
                            M_PC4 = 15'h0004, M_ILL = 15'h0002, M_DONE = 15'h0001;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] outs;
    } exp_t;

    function automatic void checkOutput(input string name, input logic [31:0] got,
                                        input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int LAT = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        localparam bit EN  = (g != 0);

        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        reg_we, dm_we, alu_src, mem_to_reg, reg_dst, ir_we, pc_we, alu_srca;
        logic [1:0]  alu_op, pc_src;
        logic        pc4, illegal, instr_done;
        logic [3:0]  st;
        logic [14:0] outs;
        logic        done_flag = 1'b0;
        logic        model_ill = 1'b0;
        exp_t        expq[$];
        exp_t        cur_exp;
        int          n;

        mc_control_unit #(.MEM_LAT(LAT), .EN_IMM(EN)) dut (
            .clk(clk), .rst(rst), .OP(op), .funct(funct), .zero(zero),
            .Reg_WE(reg_we), .DM_WE(dm_we), .ALU_src(alu_src), .MEM_to_REG(mem_to_reg),
            .REG_Dst(reg_dst), .IR_WE(ir_we), .PC_WE(pc_we), .ALU_srcA(alu_srca),
            .ALU_OP(alu_op), .PC_src(pc_src), .ALU_srcB_pc4(pc4), .illegal(illegal),
            .state(st), .instr_done(instr_done)
        );

        assign outs = {reg_we, dm_we, alu_src, mem_to_reg, reg_dst, ir_we, pc_we, alu_srca,
                       alu_op, pc_src, pc4, illegal, instr_done};

        function automatic void addExp(input logic [3:0] s, input logic [14:0] o);
            expq.push_back({s, o | (model_ill ? M_ILL : 15'h0)});
            n++;
        endfunction

        // Builds the whole cycle-by-cycle trace of one instruction, then lets it execute.
        task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z);
            op    = o;
            funct = f;
            zero  = z;
            n     = 0;
            for (int c = 0; c <= LAT; c++)
                addExp(S_FETCH, (c == LAT) ? (M_IRWE | M_PCWE | M_PC4) : 15'h0);
            addExp(S_DECODE, 15'h0);
            if (o == 6'h00 && (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) begin
                addExp(S_EXEC, M_SRCA | M_OPFN);
                addExp(S_ALUWB, M_REGWE | M_DST | M_DONE);
            end else if (o == 6'h23) begin
                addExp(S_MEMADR, M_SRCA | M_SRC);
                for (int c = 0; c <= LAT; c++) addExp(S_MEMRD, 15'h0);
                addExp(S_MEMWB, M_REGWE | M_M2R | M_DONE);
            end else if (o == 6'h2B) begin
                addExp(S_MEMADR, M_SRCA | M_SRC);
                for (int c = 0; c <= LAT; c++)
                    addExp(S_MEMWR, M_DMWE | ((c == LAT) ? M_DONE : 15'h0));
            end else if (o == 6'h04) begin
                addExp(S_BRANCH, M_SRCA | M_OPSUB | M_PCALUOUT | M_DONE | (z ? M_PCWE : 15'h0));
            end else if (o == 6'h08 && EN) begin
                addExp(S_ADDIEX, M_SRCA | M_SRC);
                addExp(S_ADDIWB, M_REGWE | M_DONE);
            end else if (o == 6'h02 && EN) begin
                addExp(S_JUMP, M_PCWE | M_PCJMP | M_DONE);
            end else begin
                model_ill = 1'b1;
            end
            repeat (n) @(posedge clk);
            #1;
        endtask

        // Monitor: every cycle with a pending expectation is compared mid-cycle.
        always @(negedge clk) begin
            if (expq.size() > 0) begin
                cur_exp = expq.pop_front();
                checkOutput($sformatf("dut%0d state", g), 32'(st), 32'(cur_exp.st));
                checkOutput($sformatf("dut%0d outputs in state %0d", g, cur_exp.st),
                            32'(outs), 32'(cur_exp.outs));
            end
        end

        initial begin
            int unsigned r;
            logic [5:0]  ro, rf;
            rst   = 1'b1;
            op    = 6'h0;
            funct = 6'h0;
            zero  = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("dut%0d reset state", g), 32'(st), 32'd0);
            checkOutput($sformatf("dut%0d reset outputs", g), 32'(outs), 32'd0);
            @(posedge clk);
            #1 rst = 1'b0;
            n = 0;
            addExp(S_IDLE, 15'h0);
            @(posedge clk);
            #1;

            applyStimulus(6'h00, 6'h20, 1'b0);
            applyStimulus(6'h23, 6'h00, 1'b0);
            applyStimulus(6'h2B, 6'h00, 1'b1);
            applyStimulus(6'h04, 6'h00, 1'b0);
            applyStimulus(6'h04, 6'h00, 1'b1);
            applyStimulus(6'h00, 6'h22, 1'b0);
            applyStimulus(6'h00, 6'h24, 1'b1);
            applyStimulus(6'h00, 6'h25, 1'b0);
            applyStimulus(6'h00, 6'h2A, 1'b0);
            applyStimulus(6'h08, 6'h00, 1'b0);
            applyStimulus(6'h02, 6'h00, 1'b0);
            applyStimulus(6'h00, 6'h00, 1'b0);
            applyStimulus(6'h00, 6'h20, 1'b0);

            for (int i = 0; i < 40; i++) begin
                r  = $urandom_range(0, 9);
                rf = 6'($urandom);
                case (r)
                    0, 1, 2: begin
                        ro = 6'h00;
                        case ($urandom_range(0, 4))
                            0: rf = 6'h20;
                            1: rf = 6'h22;
                            2: rf = 6'h24;
                            3: rf = 6'h25;
                            default: rf = 6'h2A;
                        endcase
                    end
                    3: ro = 6'h23;
                    4: ro = 6'h2B;
                    5: ro = 6'h04;
                    6: ro = 6'h08;
                    7: ro = 6'h02;
                    8: ro = 6'($urandom);
                    default: ro = 6'h00;
                endcase
                applyStimulus(ro, rf, 1'($urandom));
            end

            // Reset in the middle of a store must clear everything without a clock edge.
            op    = 6'h2B;
            funct = 6'h00;
            zero  = 1'b0;
            repeat (LAT + 3) @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("dut%0d state/DM_WE in MEMWR", g), 32'({st, dm_we}),
                        32'({S_MEMWR, 1'b1}));
            #1 rst = 1'b1;
            #1;
            checkOutput($sformatf("dut%0d async reset state/DM_WE", g), 32'({st, dm_we}), 32'd0);
            checkOutput($sformatf("dut%0d async reset outputs", g), 32'(outs), 32'd0);
            model_ill = 1'b0;
            @(posedge clk);
            #1 rst = 1'b0;
            n = 0;
            addExp(S_IDLE, 15'h0);
            @(posedge clk);
            #1;
            applyStimulus(6'h00, 6'h20, 1'b0);
            applyStimulus(6'h08, 6'h00, 1'b0);
            applyStimulus(6'h23, 6'h00, 1'b0);
            done_flag = 1'b1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(inst[0].done_flag && inst[1].done_flag && inst[2].done_flag) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 20000) begin
            failures++;
            $display("[TB] FAIL timeout: stimulus did not complete within %0d cycles", k);
        end
        repeat (2) @(posedge clk);
        checkOutput("dut0 leftover expectations", 32'(inst[0].expq.size()), 32'd0);
        checkOutput("dut1 leftover expectations", 32'(inst[1].expq.size()), 32'd0);
        checkOutput("dut2 leftover expectations", 32'(inst[2].expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter MEM_LAT, default 0, meaning extra wait cycles per memory access (range 0..15).
REQ-002 SHALL have parameter EN_IMM, default 1, meaning addi/j are supported when 1 and decode as illegal when 0.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port OP, input, 6, meaning instruction opcode, valid from DECODE onward.
REQ-006 SHALL have port funct, input, 6, meaning R-type function field.
REQ-007 SHALL have port zero, input, 1, meaning the ALU zero flag.
REQ-008 SHALL have outputs Reg_WE, DM_WE, ALU_src, MEM_to_REG, REG_Dst, IR_WE, PC_WE, ALU_srcA, each 1 bit, meaning the datapath enables and muxes.
REQ-009 SHALL have outputs ALU_OP (2 bits: 00 add, 01 sub, 10 funct) and PC_src (2 bits: 00 ALU, 01 ALUOut, 10 jump), plus ALU_srcB_pc4 (1 bit: selects constant 4).
REQ-010 SHALL have outputs illegal (1 bit, sticky), state (4 bits, current state code) and instr_done (1 bit, one-cycle pulse).

Function
REQ-011 SHALL be a Moore FSM: every output is a function of state and the wait counter only, except PC_WE in BRANCH, which is gated by zero.
REQ-012 SHALL use the state codes IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12.
REQ-013 SHALL move from IDLE to FETCH unconditionally, with all outputs 0 in IDLE.
REQ-014 SHALL hold FETCH, MEMRD and MEMWR for MEM_LAT+1 cycles using a 4-bit wait counter that loads 0 on entry and increments each cycle; the state advances when the counter equals MEM_LAT.
REQ-015 SHALL assert in FETCH, only on its final cycle: IR_WE=1, PC_WE=1, ALU_srcA=0, ALU_srcB_pc4=1, ALU_OP=00, PC_src=00.
REQ-016 SHALL transition from DECODE as follows: OP 000000 with funct in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} goes to EXEC; 100011 goes to MEMADR; 101011 goes to MEMADR; 000100 goes to BRANCH; 001000 goes to ADDIEX when EN_IMM=1; 000010 goes to JUMP when EN_IMM=1; all other opcodes set illegal=1 and go to FETCH.
REQ-017 SHALL drive ALU_srcA=1, ALU_src=1, ALU_OP=00 in MEMADR, then go to MEMRD for lw or MEMWR for sw.
REQ-018 SHALL assert DM_WE=1 in MEMWR on every cycle of the state.
REQ-019 SHALL drive Reg_WE=1, MEM_to_REG=1, REG_Dst=0 for one cycle in MEMWB.
REQ-020 SHALL drive ALU_srcA=1, ALU_src=0, ALU_OP=10 in EXEC, and Reg_WE=1, REG_Dst=1, MEM_to_REG=0 in ALUWB.
REQ-021 SHALL drive ALU_srcA=1, ALU_OP=01, PC_src=01 in BRANCH, with PC_WE equal to zero.
REQ-022 SHALL drive ALU_srcA=1, ALU_src=1, ALU_OP=00 in ADDIEX, and Reg_WE=1, REG_Dst=0 in ADDIWB.
REQ-023 SHALL drive PC_WE=1, PC_src=10 for one cycle in JUMP.
REQ-024 SHALL pulse instr_done for one cycle in each terminal state (MEMWB, MEMWR final cycle, ALUWB, BRANCH, ADDIWB, JUMP); the next state after a terminal state is FETCH.
REQ-025 SHALL never assert Reg_WE and DM_WE in the same cycle.
REQ-026 SHALL hold illegal at 1 once set, until rst; an illegal instruction does not pulse instr_done.

Reset
REQ-027 SHALL, while rst=1, force state=IDLE, wait counter=0, illegal=0 and all outputs to 0, asynchronously and regardless of the current state.
REQ-028 SHALL restart from IDLE→FETCH after rst deasserts mid-instruction, with no write enable asserted in the first cycle after release.

Verification
REQ-029 SHALL be verified with: MEM_LAT=0, OP=000000, funct=100000 → state sequence 1,2,7,8,1; Reg_WE=1 and REG_Dst=1 only in state 8.
REQ-030 SHALL be verified with: MEM_LAT=2, lw (100011) → FETCH for 3 cycles, MEMRD for 3 cycles, MEMWB for 1 cycle with Reg_WE=1 and MEM_to_REG=1; 9 cycles total.
REQ-031 SHALL be verified with: beq (000100) with zero=0 and then zero=1 → PC_WE=0 and then PC_WE=1 in BRANCH; PC_src=01 in both.
REQ-032 SHALL be verified with: EN_IMM=0, OP=001000 → illegal=1 after DECODE, next state FETCH, no instr_done; illegal stays 1 across later valid instructions.
REQ-033 SHALL be verified with: rst asserted during MEMWR with MEM_LAT=3 → DM_WE drops to 0 immediately, without waiting for a clock edge, and state=0.
REQ-034 SHALL be verified with: OP=000000, funct=000000 → illegal=1, and Reg_WE never asserted.
